alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Control/issue side of the combinational ALU interface: accepts an operation
//  request (ALUOp, funct, two operands) over valid/ready, decodes it to the 4-bit
//  ALU control code, drives the ALU, captures ALUResult/Zero into registers and
//  returns them over valid/ready. Sits between the decode stage and the ALU in
//  the multi-cycle datapath; also resolves BEQ taken/not-taken.
// PARAMETERS
//  DATA_W  32  operand/result width (ALU is 32-bit; other values unsupported)
//  CNT_W   16  width of completed-operation counter
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       request valid
//  in_ready     out  1       request accepted when in_valid & in_ready
//  in_aluop     in   2       00 add (lw/sw), 01 sub (beq), 10 R-type, 11 illegal
//  in_funct     in   6       R-type function field (used only when aluop=10)
//  in_a         in   DATA_W  operand A
//  in_b         in   DATA_W  operand B
//  alu_a        out  DATA_W  to ALU operand A
//  alu_b        out  DATA_W  to ALU operand B
//  alu_ctrl     out  4       to ALU control: 0010 add,0110 sub,0000 and,0001 or,0111 slt
//  alu_result   in   DATA_W  from ALU result
//  alu_zero     in   1       from ALU zero flag
//  out_valid    out  1       response valid
//  out_ready    in   1       response consumed when out_valid & out_ready
//  out_result   out  DATA_W  captured ALU result (0 when illegal)
//  out_zero     out  1       captured zero flag (0 when illegal)
//  out_branch   out  1       1 iff aluop=01 and captured zero=1
//  out_illegal  out  1       1 iff request was undecodable
//  op_count     out  CNT_W   number of completed legal ops, wraps to 0
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE; alu_a/alu_b=0, alu_ctrl=0010;
//    out_valid=0, out_result=0, out_zero/out_branch/out_illegal=0, op_count=0.
//  - Decode: aluop 00->0010; 01->0110; 10 with funct 100000->0010, 100010->0110,
//    100100->0000, 100101->0001, 101010->0111; any other funct or aluop 11 -> illegal.
//  - FSM IDLE: in_ready=1. On accept latch in_a, in_b, decoded code, aluop==01 into
//    alu_a/alu_b/alu_ctrl/branch-op regs; legal -> EXEC, illegal -> DONE with
//    out_illegal=1, out_result=0, out_zero=0, out_branch=0.
//  - EXEC (exactly 1 cycle): in_ready=0; ALU settles on registered inputs; at end
//    of cycle capture out_result=alu_result, out_zero=alu_zero,
//    out_branch=branch_op&alu_zero, out_illegal=0; -> DONE.
//  - DONE: in_ready=0, out_valid=1; outputs held stable while out_ready=0.
//    On out_ready: out_valid->0 next cycle, -> IDLE; op_count+1 if not illegal.
//  - Latency: accept at edge N -> out_valid high after edge N+2 (legal) or N+1
//    (illegal). Max throughput one op per 3 cycles; no back-to-back overlap.
//  - in_* ignored outside IDLE. alu_a/alu_b/alu_ctrl hold last issued values
//    after completion (no toggling while idle).
//  - op_count wraps 2^CNT_W-1 -> 0 without flag.
//  - Reset mid-operation: in-flight op discarded, no response, counter cleared.
// TESTING
//  - R-type add: aluop=10,funct=100000,a=5,b=7 -> alu_ctrl=0010, out_result=12,
//    out_zero=0, out_valid 2 cycles after accept, op_count=1.
//  - BEQ: aluop=01,a=b=32'hDEADBEEF -> alu_ctrl=0110, out_result=0, out_zero=1,
//    out_branch=1; a=3,b=4 -> out_branch=0, out_result=FFFFFFFF.
//  - SLT/AND/OR: funct 101010 a=2,b=9 ->1; 100100 F0F0,0FF0 ->00F0; 100101 ->FFF0.
//  - Illegal: aluop=11 and aluop=10,funct=000000 -> out_illegal=1, result 0,
//    out_valid 1 cycle after accept, op_count unchanged.
//  - Backpressure: hold out_ready=0 10 cycles -> outputs stable, in_ready=0,
//    new in_valid ignored; release -> IDLE, next request accepted.
//  - Async reset asserted in EXEC -> out_valid=0, state IDLE immediately, no
//    response after release; op_count preset to FFFF then one op -> 0000.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue/control wrapper around a combinational 32-bit ALU. Accepts one request over a
//   valid/ready handshake, decodes ALUOp/funct to the 4-bit ALU control code, drives the
//   ALU from registers for one EXEC cycle, captures result/zero and presents them over a
//   second valid/ready handshake. Also resolves BEQ taken/not-taken and counts completed
//   legal operations.
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       request handshake; in_aluop, in_funct, in_a, in_b request fields
//   alu_a/alu_b/alu_ctrl    registered ALU operands and control code
//   alu_result/alu_zero     combinational ALU outputs
//   out_valid/out_ready     response handshake; out_result, out_zero, out_branch, out_illegal
//   op_count                completed legal operations, wraps silently

module alu_issue_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_branch,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [3:0]          r_alu_ctrl;
  logic                r_branch_op;
  logic [DATA_W-1:0]   r_out_result;
  logic                r_out_zero;
  logic                r_out_branch;
  logic                r_out_illegal;
  logic [CNT_W-1:0]    r_op_count;

  logic [3:0]          w_dec_ctrl;
  logic                w_dec_illegal;
  logic                w_accept;
  logic                w_release;

  // Request decode
  always_comb begin
    w_dec_ctrl    = 4'b0010;
    w_dec_illegal = 1'b0;
    case (in_aluop)
      2'b00: w_dec_ctrl = 4'b0010;
      2'b01: w_dec_ctrl = 4'b0110;
      2'b10: begin
        case (in_funct)
          6'b100000: w_dec_ctrl = 4'b0010;
          6'b100010: w_dec_ctrl = 4'b0110;
          6'b100100: w_dec_ctrl = 4'b0000;
          6'b100101: w_dec_ctrl = 4'b0001;
          6'b101010: w_dec_ctrl = 4'b0111;
          default:   w_dec_illegal = 1'b1;
        endcase
      end
      default: w_dec_illegal = 1'b1;
    endcase
  end

  assign w_accept  = in_valid && (r_state == StIdle);
  assign w_release = out_ready && (r_state == StDone);

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = w_dec_illegal ? StDone : StExec;
      end
      StExec: w_state_next = StDone;
      StDone: begin
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_ctrl    <= 4'b0010;
      r_branch_op   <= 1'b0;
      r_out_result  <= '0;
      r_out_zero    <= 1'b0;
      r_out_branch  <= 1'b0;
      r_out_illegal <= 1'b0;
      r_op_count    <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a       <= in_a;
        r_alu_b       <= in_b;
        r_branch_op   <= (in_aluop == 2'b01);
        r_out_illegal <= w_dec_illegal;
        // An undecodable request keeps the last legal code on the ALU bus
        if (!w_dec_illegal) begin
          r_alu_ctrl <= w_dec_ctrl;
        end else begin
          r_out_result <= '0;
          r_out_zero   <= 1'b0;
          r_out_branch <= 1'b0;
        end
      end
      if (r_state == StExec) begin
        r_out_result  <= alu_result;
        r_out_zero    <= alu_zero;
        r_out_branch  <= r_branch_op & alu_zero;
        r_out_illegal <= 1'b0;
      end
      if (w_release && !r_out_illegal) r_op_count <= r_op_count + 1'b1;
    end
  end

  assign in_ready    = (r_state == StIdle);
  assign out_valid   = (r_state == StDone);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_ctrl    = r_alu_ctrl;
  assign out_result  = r_out_result;
  assign out_zero    = r_out_zero;
  assign out_branch  = r_out_branch;
  assign out_illegal = r_out_illegal;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU closes the loop, a vector table drives
// requests, a scoreboard queue holds expected responses that a negedge monitor pops
// on each response handshake. A narrow counter width keeps the wrap test short.

module tb_alu_issue_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_aluop;
  logic [5:0]        in_funct;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_branch;
  logic              out_illegal;
  logic [CNT_W-1:0]  op_count;

  alu_issue_ctrl #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_aluop    (in_aluop),
    .in_funct    (in_funct),
    .in_a        (in_a),
    .in_b        (in_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_branch  (out_branch),
    .out_illegal (out_illegal),
    .op_count    (op_count)
  );

  // Behavioural 32-bit ALU
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_branch;
    logic        exp_illegal;
    logic [3:0]  exp_ctrl;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];
  vec_t sb [$];

  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: out_ready only changes #1 after posedge, so negedge is stable
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_response", 64'd1, 64'd0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("out_result",  out_result,  e.exp_result);
        chk("out_zero",    out_zero,    e.exp_zero);
        chk("out_branch",  out_branch,  e.exp_branch);
        chk("out_illegal", out_illegal, e.exp_illegal);
      end
    end
  end

  // One full transaction; hold = extra cycles of out_ready=0 with junk requests offered
  task automatic run_op(input vec_t v, input int hold);
    int                cnt;
    logic [DATA_W-1:0] h_res;
    logic              h_zero;
    logic              h_br;
    logic              h_ill;
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_aluop = v.aluop;
    in_funct = v.funct;
    in_a     = v.a;
    in_b     = v.b;
    @(posedge clk);
    sb.push_back(v);
    n_vec++;
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    // Cycles from accept until out_valid: EXEC adds one for legal ops
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 8);
    chk("latency", cnt, v.exp_illegal ? 1 : 2);
    if (!v.exp_illegal) chk("alu_ctrl", alu_ctrl, v.exp_ctrl);
    h_res  = out_result;
    h_zero = out_zero;
    h_br   = out_branch;
    h_ill  = out_illegal;
    if (hold > 0) begin
      in_valid = 1'b1;
      in_aluop = 2'b00;
      in_a     = 32'h1111_1111;
      in_b     = 32'h2222_2222;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready",  in_ready,  0);
        chk("bp_result",    out_result, h_res);
        chk("bp_flags",     {out_zero, out_branch, out_illegal}, {h_zero, h_br, h_ill});
        chk("bp_alu_a",     alu_a, v.a);
      end
      in_valid = 1'b0;
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    if (!v.exp_illegal) exp_cnt++;
    @(negedge clk);
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready",  in_ready,  1);
    chk("op_count",       op_count,  exp_cnt);
  endtask

  initial begin
    //           aluop  funct      a             b             result        z     br    ill   ctrl
    vecs[0]  = '{2'b10, 6'b100000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0, 4'b0010};
    vecs[1]  = '{2'b01, 6'b000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0,        1'b1, 1'b1, 1'b0, 4'b0110};
    vecs[2]  = '{2'b01, 6'b100101, 32'd3,        32'd4,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4'b0110};
    vecs[3]  = '{2'b10, 6'b101010, 32'd2,        32'd9,        32'd1,        1'b0, 1'b0, 1'b0, 4'b0111};
    vecs[4]  = '{2'b10, 6'b100100, 32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{2'b10, 6'b100101, 32'hF0F0,     32'h0FF0,     32'hFFF0,     1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[6]  = '{2'b11, 6'b100000, 32'd1,        32'd2,        32'd0,        1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[7]  = '{2'b10, 6'b000000, 32'd1,        32'd2,        32'd0,        1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[8]  = '{2'b00, 6'b111111, 32'd10,       32'd20,       32'd30,       1'b0, 1'b0, 1'b0, 4'b0010};
    vecs[9]  = '{2'b10, 6'b100010, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b0, 4'b0110};
    vecs[10] = '{2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0, 4'b0010};
    vecs[11] = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 4'b0111};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_aluop  = 2'b00;
    in_funct  = 6'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_alu_ctrl",  alu_ctrl,  4'b0010);
    chk("rst_alu_ab",    {alu_a, alu_b}, 64'd0);
    chk("rst_outputs",   {out_result, out_zero, out_branch, out_illegal}, 35'd0);
    chk("rst_op_count",  op_count,  0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_op(vecs[i], 0);

    // Backpressure: ten stalled cycles, then the next request must go through
    run_op(vecs[0], 10);
    run_op(vecs[1], 0);

    // Reset asserted while the op is in EXEC
    @(negedge clk);
    in_valid = 1'b1;
    in_aluop = vecs[3].aluop;
    in_funct = vecs[3].funct;
    in_a     = vecs[3].a;
    in_b     = vecs[3].b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("exec_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready",  in_ready,  1);
    chk("mid_rst_op_count",  op_count,  0);
    chk("mid_rst_alu_ctrl",  alu_ctrl,  4'b0010);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_resp_after_rst", out_valid, 0);
    end

    // Counter wrap: all-ones plus one legal op returns to zero
    for (int i = 0; i < (1 << CNT_W); i++) run_op(vecs[i % 2], 0);
    chk("wrap_op_count", op_count, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
